tdm_demux: RTL
==============

Name: tdm_demux

Overview:
- Receive end of the team's time-division-multiplexed serial link; the mux side interleaves NCH channel words onto one bit line.
- Deserialises the stream MSB-first and tracks frame alignment from a frame-sync pulse.
- Steers each recovered word to its channel holding register and flags loss of alignment.
- Sits between the serial link input and the per-channel consumers.

Parameters:
- NCH, 4, number of channel slots per frame (power of 2, at least 2).
- W, 8, bits per slot (at least 2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-low.
- din  input  1  serial data bit; one bit per cycle, MSB of each slot first.
- fsync  input  1  high for exactly the cycle carrying bit W-1 of slot 0.
- dout  output  W  most recently completed slot word.
- ch_sel  output  clog2(NCH)  slot index of dout.
- dout_valid  output  1  one-cycle strobe: dout and ch_sel are new.
- frame_done  output  1  one-cycle strobe, coincident with dout_valid for slot NCH-1.
- ch_out  output  NCH*W  per-channel holding registers; channel k occupies bits [k*W+W-1 : k*W].
- locked  output  1  high while in RUN.
- sync_err  output  1  one-cycle strobe on an alignment violation.

Behaviour:
- Reset (rst=0, asynchronous): state HUNT; bit counter, slot counter and shift register cleared; all outputs 0, including ch_out. Reset asserted mid-frame aborts the frame immediately and produces no strobes.
- FSM has two states, HUNT and RUN. locked=1 exactly when state=RUN.
- HUNT:
  - din is ignored and no strobes are produced while fsync=0.
  - fsync=1: din is taken as bit W-1 of slot 0, bit count=1, slot=0, next state RUN.
- RUN, each cycle:
  - The shift register shifts din in at the LSB side.
  - The bit counter increments from 0 to W-1, then wraps to 0.
  - The slot counter increments when the bit counter wraps, and wraps from NCH-1 to 0.
- Slot completion: the clock edge that samples the last bit (bit count W-1) registers:
  - dout = {shift[W-2:0], din};
  - ch_sel = current slot;
  - ch_out slice for the current slot = the same word;
  - dout_valid=1 for the following cycle.
  - Latency: dout is visible in the cycle after the LSB is on din. The slot starting with fsync at cycle T gives dout_valid in cycle T+W.
- frame_done=1 with dout_valid when ch_sel=NCH-1. Frame period is NCH*W cycles.
- dout, ch_sel and ch_out hold between strobes. ch_out slices change only at their own slot completion.
- Alignment checking (RUN only):
  - Expected fsync cycle is bit 0 of slot 0, i.e. the cycle after frame completion.
  - fsync=1 at the expected cycle: normal, continue in RUN.
  - fsync=0 at the expected cycle: sync_err=1 next cycle, state HUNT, locked=0 next cycle. That cycle's din is discarded. The preceding frame's strobes still occur normally.
  - fsync=1 at any unexpected cycle: sync_err=1 next cycle, the partial slot is discarded (no dout_valid), and the frame restarts in RUN with this cycle as bit W-1 of slot 0. locked stays 1.
  - An fsync arriving in the same cycle as a slot's last bit is unexpected. It does not complete that slot and takes the restart path above.
- ch_out is not cleared on sync_err; previous values remain.
- Counter widths: clog2(W) bits and clog2(NCH) bits. With power-of-2 NCH, the slot counter wraps naturally.

Test Plan:
- Reset then idle, din toggling, fsync=0 for 50 cycles -> all outputs 0, locked=0, no strobes.
- NCH=4, W=8, fsync at cycle T, frame bytes A5,3C,0F,81 MSB-first ->
  - dout_valid at T+8, T+16, T+24, T+32 with ch_sel 0..3 and dout A5,3C,0F,81;
  - frame_done only at T+32;
  - ch_out=32'h810F3CA5;
  - locked=1 from T+1.
- Two back-to-back frames with fsync at T and T+32; second frame 11,22,33,44 -> no sync_err, ch_out=32'h44332211, 8 dout_valid strobes total.
- fsync omitted at T+32 -> sync_err at T+33, locked=0 at T+33. A later fsync at T+40 with frame 01,02,03,04 -> relock, ch_out=32'h04030201.
- fsync re-asserted at T+12 (slot 1, bit 4) -> sync_err at T+13, no dout_valid for slot 1. Frame restarts: dout_valid ch_sel=0 at T+20. ch_out slot 0 keeps the first frame's value until T+20.
- rst pulsed low at T+10 during a frame -> outputs 0 immediately; no strobes until the next fsync after rst=1.

Source files
------------

// File: rtl/tdm_demux.sv
// rtl/tdm_demux.sv - TDM serial link receiver: deserialise, align to fsync, steer slot words
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous reset, active-low
//   din         serial data, one bit per cycle, MSB of each slot first
//   fsync       frame sync, high on the cycle carrying the MSB of slot 0
//   dout        most recently completed slot word
//   ch_sel      slot index of dout
//   dout_valid  one-cycle strobe, dout/ch_sel just updated
//   frame_done  one-cycle strobe with dout_valid for the last slot of a frame
//   ch_out      per-channel holding registers, channel k at [k*W +: W]
//   locked      high while frame alignment is held (RUN)
//   sync_err    one-cycle strobe on an alignment violation

module tdm_demux #(
    parameter int NCH = 4,
    parameter int W   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   din,
    input  logic                   fsync,
    output logic [W-1:0]           dout,
    output logic [$clog2(NCH)-1:0] ch_sel,
    output logic                   dout_valid,
    output logic                   frame_done,
    output logic [NCH*W-1:0]       ch_out,
    output logic                   locked,
    output logic                   sync_err
);

    localparam int BW = $clog2(W);
    localparam int SW = $clog2(NCH);
    localparam logic [BW-1:0] BIT_LAST  = BW'(W - 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(NCH - 1);
    localparam logic [BW-1:0] BIT_ONE   = BW'(1);
    localparam logic [SW-1:0] SLOT_ONE  = SW'(1);

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state;
    logic [BW-1:0] bit_cnt;
    logic [SW-1:0] slot_cnt;
    logic [W-2:0]  shift;

    logic [W-1:0]  word_nxt;
    logic          frame_start;
    logic          slot_end;

    // Only W-1 bits are stored; the current din completes the word.
    assign word_nxt    = {shift, din};
    // Bit 0 of slot 0: the one cycle where fsync is expected while locked.
    assign frame_start = (bit_cnt == '0) && (slot_cnt == '0);
    assign slot_end    = (bit_cnt == BIT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= HUNT;
            bit_cnt    <= '0;
            slot_cnt   <= '0;
            shift      <= '0;
            dout       <= '0;
            ch_sel     <= '0;
            dout_valid <= 1'b0;
            frame_done <= 1'b0;
            ch_out     <= '0;
            locked     <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;

            case (state)
                HUNT: begin
                    if (fsync) begin
                        shift    <= word_nxt[W-2:0];
                        bit_cnt  <= BIT_ONE;
                        slot_cnt <= '0;
                        state    <= RUN;
                        locked   <= 1'b1;
                    end
                end

                RUN: begin
                    if (fsync) begin
                        // fsync always (re)starts slot 0 with this bit as MSB.
                        // Off the expected cycle it is an alignment error and
                        // the partial slot, even one on its last bit, is dropped.
                        sync_err <= !frame_start;
                        shift    <= word_nxt[W-2:0];
                        bit_cnt  <= BIT_ONE;
                        slot_cnt <= '0;
                    end else if (frame_start) begin
                        // Missing fsync: drop alignment, discard this bit.
                        sync_err <= 1'b1;
                        state    <= HUNT;
                        locked   <= 1'b0;
                        shift    <= '0;
                    end else if (slot_end) begin
                        dout                    <= word_nxt;
                        ch_sel                  <= slot_cnt;
                        ch_out[slot_cnt*W +: W] <= word_nxt;
                        dout_valid              <= 1'b1;
                        frame_done              <= (slot_cnt == SLOT_LAST);
                        shift                   <= word_nxt[W-2:0];
                        bit_cnt                 <= '0;
                        // NCH is a power of two, so this wraps to slot 0.
                        slot_cnt                <= slot_cnt + SLOT_ONE;
                    end else begin
                        shift   <= word_nxt[W-2:0];
                        bit_cnt <= bit_cnt + BIT_ONE;
                    end
                end

                default: begin
                    state  <= HUNT;
                    locked <= 1'b0;
                end
            endcase
        end
    end

endmodule
